// File: rtl/pic_ctrl_pkg.sv
// rtl/pic_ctrl_pkg.sv - shared constants, state codes and init-step helpers for the PIC host sequencer
package pic_ctrl_pkg;

    // Sequencer states, kept as plain constants for legacy tool flows
    localparam logic [3:0] ST_INIT_SETUP  = 4'd0;
    localparam logic [3:0] ST_INIT_STROBE = 4'd1;
    localparam logic [3:0] ST_INIT_HOLD   = 4'd2;
    localparam logic [3:0] ST_READY       = 4'd3;
    localparam logic [3:0] ST_ACK1        = 4'd4;
    localparam logic [3:0] ST_ACK_GAP     = 4'd5;
    localparam logic [3:0] ST_ACK2        = 4'd6;
    localparam logic [3:0] ST_VEC_HOLD    = 4'd7;
    localparam logic [3:0] ST_EOI_SETUP   = 4'd8;
    localparam logic [3:0] ST_EOI_STROBE  = 4'd9;
    localparam logic [3:0] ST_EOI_HOLD    = 4'd10;

    // Position in the initialisation word list
    typedef enum logic [2:0] {
        STEP_ICW1,
        STEP_ICW2,
        STEP_ICW3,
        STEP_ICW4,
        STEP_OCW1,
        STEP_DONE
    } step_e;

    localparam logic A0_CMD  = 1'b0;
    localparam logic A0_DATA = 1'b1;

    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_IC4_BIT  = 0;

    localparam logic [7:0] OCW2_NS_EOI = 8'h20;

    // ICW3 only exists in cascade mode (SNGL=0); ICW4 only when IC4=1
    function automatic step_e next_step(input step_e cur, input logic sngl, input logic ic4);
        case (cur)
            STEP_ICW1: return STEP_ICW2;
            STEP_ICW2: return !sngl ? STEP_ICW3 : (ic4 ? STEP_ICW4 : STEP_OCW1);
            STEP_ICW3: return ic4 ? STEP_ICW4 : STEP_OCW1;
            STEP_ICW4: return STEP_OCW1;
            default:   return STEP_DONE;
        endcase
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// rtl/pic_bus_cycle.sv - single PIC write-cycle timer (setup, WR strobe, hold)
module pic_bus_cycle #(
    parameter int STROBE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_go,
    input  logic       i_a0,
    input  logic [7:0] i_data,
    output logic       o_cs_n,
    output logic       o_wr_n,
    output logic       o_a0,
    output logic [7:0] o_d_out,
    output logic       o_d_oe,
    output logic       o_done
);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_STROBE = 2'd2;
    localparam logic [1:0] PH_HOLD   = 2'd3;

    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    logic [1:0]    r_phase;
    logic [CW-1:0] r_cnt;
    logic          r_a0;
    logic [7:0]    r_data;
    logic          w_accept;
    logic          w_strobe_last;

    // A new write may be launched from the HOLD cycle so writes run back to back
    assign w_accept      = i_go && ((r_phase == PH_IDLE) || (r_phase == PH_HOLD));
    assign w_strobe_last = (r_phase == PH_STROBE) && (r_cnt == CW'(STROBE_CYC - 1));

    assign o_cs_n  = (r_phase == PH_IDLE);
    assign o_wr_n  = (r_phase != PH_STROBE);
    assign o_d_oe  = (r_phase != PH_IDLE);
    assign o_a0    = r_a0;
    assign o_d_out = r_data;
    // done flags the final strobe cycle; HOLD follows on the next edge
    assign o_done  = w_strobe_last;

    // Phase sequencer; address and data are latched once per write and held through HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_a0    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            case (r_phase)
                PH_SETUP: begin
                    r_phase <= PH_STROBE;
                    r_cnt   <= '0;
                end
                PH_STROBE: begin
                    if (w_strobe_last) begin
                        r_phase <= PH_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_phase <= PH_SETUP;
                        r_a0    <= i_a0;
                        r_data  <= i_data;
                    end else begin
                        r_phase <= PH_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pic_host_sequencer.sv
// rtl/pic_host_sequencer.sv - host-side init, INTA acknowledge and EOI sequencer for an 8259-style PIC
module pic_host_sequencer
    import pic_ctrl_pkg::*;
#(
    parameter int         STROBE_CYC = 2,
    parameter int         INTA_CYC   = 2,
    parameter logic [7:0] ICW1_VAL   = 8'h17,
    parameter logic [7:0] ICW2_VAL   = 8'h20,
    parameter logic [7:0] ICW3_VAL   = 8'h00,
    parameter logic [7:0] ICW4_VAL   = 8'h01,
    parameter logic [7:0] OCW1_VAL   = 8'h00,
    parameter logic [7:0] EOI_CMD    = OCW2_NS_EOI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       eoi_req,
    input  logic       vec_ready,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       init_done,
    output logic       eoi_pending,
    input  logic       pic_int,
    output logic       pic_inta_n,
    output logic       pic_cs_n,
    output logic       pic_wr_n,
    output logic       pic_rd_n,
    output logic       pic_a0,
    output logic [7:0] pic_d_out,
    output logic       pic_d_oe,
    input  logic [7:0] pic_d_in
);

    localparam int IW = (INTA_CYC > 1) ? $clog2(INTA_CYC) : 1;

    logic [3:0]    r_state;
    step_e         r_step;
    logic [IW-1:0] r_icnt;
    logic          r_int_s1;
    logic          r_int_s2;
    logic          r_start_pend;
    logic          r_eoi_pending;
    logic          r_init_done;
    logic          r_vec_valid;
    logic [7:0]    r_vec_data;
    logic          r_inta_n;

    logic          w_int_s;
    logic          w_start_any;
    logic          w_busy_other;
    logic          w_inta_last;
    logic          w_bus_done;
    logic          w_eoi_clear;
    step_e         w_next_step;
    step_e         w_go_step;
    logic          w_init_go;
    logic          w_eoi_go;
    logic          w_go;
    logic          w_go_a0;
    logic [7:0]    w_go_data;
    logic          w_step_a0;
    logic [7:0]    w_step_data;

    assign w_int_s      = r_int_s2;
    assign w_start_any  = start || r_start_pend;
    assign w_busy_other = (r_state == ST_ACK1) || (r_state == ST_ACK_GAP) || (r_state == ST_ACK2) ||
                          (r_state == ST_VEC_HOLD) || (r_state == ST_EOI_SETUP) ||
                          (r_state == ST_EOI_STROBE) || (r_state == ST_EOI_HOLD);
    assign w_inta_last  = (r_icnt == IW'(INTA_CYC - 1));
    assign w_eoi_clear  = (r_state == ST_EOI_STROBE) && w_bus_done;
    assign w_next_step  = next_step(r_step, ICW1_VAL[ICW1_SNGL_BIT], ICW1_VAL[ICW1_IC4_BIT]);

    // Decide whether a write launches this cycle and with which word
    always_comb begin
        w_init_go = ((r_state == ST_READY) && w_start_any) ||
                    ((r_state == ST_INIT_HOLD) && (w_next_step != STEP_DONE));
        w_eoi_go  = (r_state == ST_READY) && !w_start_any && r_eoi_pending;
        w_go_step = (r_state == ST_READY) ? STEP_ICW1 : w_next_step;
        w_step_a0   = A0_DATA;
        w_step_data = 8'h00;
        case (w_go_step)
            STEP_ICW1: begin w_step_a0 = A0_CMD;  w_step_data = ICW1_VAL; end
            STEP_ICW2: begin w_step_a0 = A0_DATA; w_step_data = ICW2_VAL; end
            STEP_ICW3: begin w_step_a0 = A0_DATA; w_step_data = ICW3_VAL; end
            STEP_ICW4: begin w_step_a0 = A0_DATA; w_step_data = ICW4_VAL; end
            STEP_OCW1: begin w_step_a0 = A0_DATA; w_step_data = OCW1_VAL; end
            default:   begin w_step_a0 = A0_DATA; w_step_data = 8'h00;    end
        endcase
        w_go      = w_init_go || w_eoi_go;
        w_go_a0   = w_eoi_go ? A0_CMD  : w_step_a0;
        w_go_data = w_eoi_go ? EOI_CMD : w_step_data;
    end

    pic_bus_cycle #(
        .STROBE_CYC (STROBE_CYC)
    ) u_bus (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_go    (w_go),
        .i_a0    (w_go_a0),
        .i_data  (w_go_data),
        .o_cs_n  (pic_cs_n),
        .o_wr_n  (pic_wr_n),
        .o_a0    (pic_a0),
        .o_d_out (pic_d_out),
        .o_d_oe  (pic_d_oe),
        .o_done  (w_bus_done)
    );

    // Two-flop synchroniser for the asynchronous INT line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_s1 <= 1'b0;
            r_int_s2 <= 1'b0;
        end else begin
            r_int_s1 <= pic_int;
            r_int_s2 <= r_int_s1;
        end
    end

    // EOI request latch; a new request merges with, and wins over, a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eoi_pending <= 1'b0;
        end else begin
            r_eoi_pending <= (r_eoi_pending && !w_eoi_clear) || eoi_req;
        end
    end

    // Main sequencer: init list, INTA pulses, vector hand-off and EOI writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_READY;
            r_step       <= STEP_ICW1;
            r_icnt       <= '0;
            r_start_pend <= 1'b1;
            r_init_done  <= 1'b0;
            r_vec_valid  <= 1'b0;
            r_vec_data   <= 8'h00;
            r_inta_n     <= 1'b1;
        end else begin
            if (start && w_busy_other) begin
                r_start_pend <= 1'b1;
            end
            if (r_vec_valid && vec_ready) begin
                r_vec_valid <= 1'b0;
            end
            case (r_state)
                ST_READY: begin
                    if (w_start_any) begin
                        r_state      <= ST_INIT_SETUP;
                        r_step       <= STEP_ICW1;
                        r_init_done  <= 1'b0;
                        r_start_pend <= 1'b0;
                    end else if (r_eoi_pending) begin
                        r_state <= ST_EOI_SETUP;
                    end else if (w_int_s && !r_vec_valid) begin
                        r_state  <= ST_ACK1;
                        r_inta_n <= 1'b0;
                        r_icnt   <= '0;
                    end
                end
                ST_INIT_SETUP:  r_state <= ST_INIT_STROBE;
                ST_INIT_STROBE: if (w_bus_done) r_state <= ST_INIT_HOLD;
                ST_INIT_HOLD: begin
                    if (w_next_step != STEP_DONE) begin
                        r_state <= ST_INIT_SETUP;
                        r_step  <= w_next_step;
                    end else begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_ACK1: begin
                    if (w_inta_last) begin
                        r_state  <= ST_ACK_GAP;
                        r_inta_n <= 1'b1;
                        r_icnt   <= '0;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                ST_ACK_GAP: begin
                    if (w_inta_last) begin
                        r_state  <= ST_ACK2;
                        r_inta_n <= 1'b0;
                        r_icnt   <= '0;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                ST_ACK2: begin
                    if (w_inta_last) begin
                        r_state     <= ST_VEC_HOLD;
                        r_inta_n    <= 1'b1;
                        r_vec_data  <= pic_d_in;
                        r_vec_valid <= 1'b1;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                ST_VEC_HOLD:   r_state <= ST_READY;
                ST_EOI_SETUP:  r_state <= ST_EOI_STROBE;
                ST_EOI_STROBE: if (w_bus_done) r_state <= ST_EOI_HOLD;
                ST_EOI_HOLD:   r_state <= ST_READY;
                default:       r_state <= ST_READY;
            endcase
        end
    end

    assign vec_valid   = r_vec_valid;
    assign vec_data    = r_vec_data;
    assign init_done   = r_init_done;
    assign eoi_pending = r_eoi_pending;
    assign pic_inta_n  = r_inta_n;
    assign pic_rd_n    = 1'b1;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb/tb_pic_host_sequencer.sv - directed self-checking bench for pic_host_sequencer
module tb_pic_host_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       eoi_req = 1'b0;
    logic       vec_ready = 1'b0;
    logic       pic_int = 1'b0;
    logic       vec_valid, init_done, eoi_pending;
    logic [7:0] vec_data;
    logic       pic_inta_n, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_d_oe;
    logic [7:0] pic_d_out;
    logic [7:0] pic_d_in;

    logic       zero1 = 1'b0;
    logic [7:0] zero8 = 8'h00;
    logic       vec_valid2, init_done2, eoi_pending2;
    logic [7:0] vec_data2;
    logic       inta_n2, cs_n2, wr_n2, rd_n2, a0_2, d_oe2;
    logic [7:0] d_out2;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_inta = 0;
    logic [8:0] wq[$];
    logic [8:0] wq2[$];

    always #5 clk = ~clk;

    pic_host_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eoi_req(eoi_req), .vec_ready(vec_ready),
        .vec_valid(vec_valid), .vec_data(vec_data), .init_done(init_done), .eoi_pending(eoi_pending),
        .pic_int(pic_int), .pic_inta_n(pic_inta_n), .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n),
        .pic_rd_n(pic_rd_n), .pic_a0(pic_a0), .pic_d_out(pic_d_out), .pic_d_oe(pic_d_oe),
        .pic_d_in(pic_d_in)
    );

    pic_host_sequencer #(.ICW1_VAL(8'h14)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(zero1), .eoi_req(zero1), .vec_ready(zero1),
        .vec_valid(vec_valid2), .vec_data(vec_data2), .init_done(init_done2), .eoi_pending(eoi_pending2),
        .pic_int(zero1), .pic_inta_n(inta_n2), .pic_cs_n(cs_n2), .pic_wr_n(wr_n2),
        .pic_rd_n(rd_n2), .pic_a0(a0_2), .pic_d_out(d_out2), .pic_d_oe(d_oe2),
        .pic_d_in(zero8)
    );

    // PIC model: vector 0x20 + IR3 driven during the second INTA pulse
    always @(negedge pic_inta_n) n_inta = n_inta + 1;
    assign pic_d_in = (!pic_inta_n && n_inta == 2) ? 8'h23 : 8'h00;

    // Record every completed write as {a0, data} at the WR rising edge
    always @(posedge pic_wr_n) if (rst_n) wq.push_back({pic_a0, pic_d_out});
    always @(posedge wr_n2) if (rst_n) wq2.push_back({a0_2, d_out2});

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({pic_inta_n, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_d_oe, vec_valid, init_done, eoi_pending} !== 9'b1111_00000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 111100000",
                     {pic_inta_n, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_d_oe, vec_valid, init_done, eoi_pending});
        end
        n_checks++;
        if ({pic_d_out, vec_data} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data got d_out=%h vec_data=%h want 00 00", pic_d_out, vec_data);
        end
    endtask

    task automatic check_init_timing(input string tag);
        repeat (16) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b0 || init_done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early got init_done=%b/%b want 0/0", tag, init_done, init_done2);
        end
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || init_done2 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done got init_done=%b/%b want 1/1", tag, init_done, init_done2);
        end
    endtask

    task automatic check_init_words(input string tag);
        logic [8:0] exp1[4];
        logic [8:0] exp2[4];
        logic [8:0] got;
        exp1 = '{9'h017, 9'h120, 9'h101, 9'h100};
        exp2 = '{9'h014, 9'h120, 9'h100, 9'h100};
        n_checks++;
        if (wq.size() != 4 || wq2.size() != 4) begin
            n_fail++;
            $display("FAIL %s_count got %0d/%0d writes want 4/4", tag, wq.size(), wq2.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < wq.size()) ? wq[i] : 9'h1ff;
            n_checks++;
            if (got !== exp1[i]) begin
                n_fail++;
                $display("FAIL %s_word%0d got a0/data=%h want %h", tag, i, got, exp1[i]);
            end
            got = (i < wq2.size()) ? wq2[i] : 9'h1ff;
            n_checks++;
            if (got !== exp2[i]) begin
                n_fail++;
                $display("FAIL %s_icw3_word%0d got a0/data=%h want %h", tag, i, got, exp2[i]);
            end
        end
    endtask

    task automatic test_init_after_reset;
        wq.delete();
        wq2.delete();
        rst_n = 1'b1;
        check_init_timing("init");
        check_init_words("init");
    endtask

    task automatic wait_inta_low(input string tag);
        int t = 0;
        while (pic_inta_n !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL %s_timeout got inta_n=%b want 0 within 20 cycles", tag, pic_inta_n);
        end
    endtask

    task automatic handshake(input string tag);
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        n_checks++;
        if (vec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_vec_clear got vec_valid=%b want 0", tag, vec_valid);
        end
    endtask

    task automatic test_ack;
        logic [6:0] exp_inta;
        logic       bad;
        exp_inta = 7'b0011001;
        n_inta = 0;
        pic_int = 1'b1;
        wait_inta_low("ack");
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (pic_inta_n !== exp_inta[6 - i] || pic_d_oe !== 1'b0 || pic_cs_n !== 1'b1) begin
                n_fail++;
                $display("FAIL ack_pulse%0d got inta_n=%b d_oe=%b cs_n=%b want %b 0 1",
                         i, pic_inta_n, pic_d_oe, pic_cs_n, exp_inta[6 - i]);
            end
            if (i < 6) @(negedge clk);
        end
        n_checks++;
        if (vec_valid !== 1'b1 || vec_data !== 8'h23) begin
            n_fail++;
            $display("FAIL ack_vector got valid=%b data=%h want 1 23", vec_valid, vec_data);
        end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (vec_valid !== 1'b1 || vec_data !== 8'h23 || pic_inta_n !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_stall got valid=%b data=%h inta_n=%b want stable 1 23 1", vec_valid, vec_data, pic_inta_n);
        end
        pic_int = 1'b0;
        repeat (3) @(negedge clk);
        handshake("ack");
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pic_inta_n !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_no_retrigger got extra INTA want none");
        end
    endtask

    task automatic test_eoi_merge;
        int t = 0;
        wq.delete();
        n_inta = 0;
        pic_int = 1'b1;
        wait_inta_low("eoi_ack");
        eoi_req = 1'b1;
        @(negedge clk);
        eoi_req = 1'b0;
        @(negedge clk);
        eoi_req = 1'b1;
        @(negedge clk);
        eoi_req = 1'b0;
        pic_int = 1'b0;
        n_checks++;
        if (eoi_pending !== 1'b1 || pic_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL eoi_latched got pending=%b cs_n=%b want 1 1", eoi_pending, pic_cs_n);
        end
        while (pic_cs_n !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL eoi_start_timeout got cs_n=%b want 0 within 20 cycles", pic_cs_n);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (eoi_pending !== 1'b1 || pic_wr_n !== 1'b0) begin
            n_fail++;
            $display("FAIL eoi_strobe got pending=%b wr_n=%b want 1 0", eoi_pending, pic_wr_n);
        end
        @(negedge clk);
        n_checks++;
        if (eoi_pending !== 1'b0 || pic_wr_n !== 1'b1 || pic_cs_n !== 1'b0) begin
            n_fail++;
            $display("FAIL eoi_hold got pending=%b wr_n=%b cs_n=%b want 0 1 0", eoi_pending, pic_wr_n, pic_cs_n);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== 9'h020)) begin
            n_fail++;
            $display("FAIL eoi_single_write got %0d writes first=%h want 1 write 020",
                     wq.size(), (wq.size() > 0) ? wq[0] : 9'h1ff);
        end
        n_checks++;
        if (vec_valid !== 1'b1 || vec_data !== 8'h23) begin
            n_fail++;
            $display("FAIL eoi_vector got valid=%b data=%h want 1 23", vec_valid, vec_data);
        end
        handshake("eoi");
    endtask

    task automatic test_start_in_vec_hold;
        int   t = 0;
        logic bad = 1'b0;
        wq.delete();
        wq2.delete();
        n_inta = 0;
        pic_int = 1'b1;
        while (vec_valid !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 30) begin
            n_fail++;
            $display("FAIL restart_vec_timeout got vec_valid=%b want 1 within 30 cycles", vec_valid);
        end
        start = 1'b1;
        pic_int = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ready got init_done=%b want 1", init_done);
        end
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_drop got init_done=%b want 0", init_done);
        end
        t = 0;
        while (init_done !== 1'b1 && t < 40) begin
            if (vec_valid !== 1'b1) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL restart_done_timeout got init_done=%b want 1 within 40 cycles", init_done);
        end
        n_checks++;
        if (bad !== 1'b0 || vec_valid !== 1'b1 || vec_data !== 8'h23) begin
            n_fail++;
            $display("FAIL restart_vec_hold got valid=%b data=%h want held 1 23", vec_valid, vec_data);
        end
        n_checks++;
        if (wq.size() != 4 || (wq.size() == 4 && (wq[0] !== 9'h017 || wq[3] !== 9'h100))) begin
            n_fail++;
            $display("FAIL restart_words got %0d writes want 4 (017..100)", wq.size());
        end
        handshake("restart");
    endtask

    task automatic test_reset_mid_ack;
        int t = 0;
        n_inta = 0;
        pic_int = 1'b1;
        while (!(n_inta == 2 && pic_inta_n === 1'b0) && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 30) begin
            n_fail++;
            $display("FAIL rst_ack2_timeout got n_inta=%0d want 2 within 30 cycles", n_inta);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pic_inta_n !== 1'b1 || pic_d_oe !== 1'b0 || vec_valid !== 1'b0 || pic_cs_n !== 1'b1 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ack got inta_n=%b d_oe=%b valid=%b cs_n=%b done=%b want 1 0 0 1 0",
                     pic_inta_n, pic_d_oe, vec_valid, pic_cs_n, init_done);
        end
        pic_int = 1'b0;
        @(negedge clk);
        wq.delete();
        wq2.delete();
        rst_n = 1'b1;
        check_init_timing("reinit");
        check_init_words("reinit");
    endtask

    initial begin
        test_reset();
        test_init_after_reset();
        test_ack();
        test_eoi_merge();
        test_start_in_vec_hold();
        test_reset_mid_ack();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
